// File: rtl/mips_pkg.sv
// mips_pkg: write-back select encodings and register constants shared by the MIPS pipeline
package mips_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_ILL = 2'b11
  } wb_sel_e;
  localparam int RA_REG   = 31;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/mem_wb_stage_retire_counter.sv
// retire_counter: wrapping instruction counter with enable and synchronous active-low reset
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register driving the write-back mux, register-file port and forwarding
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RA_REG = mips_pkg::RA_REG,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] wb_a,
  output logic [DATA_W-1:0] wb_b,
  output logic [DATA_W-1:0] wb_pc_plus4,
  output logic              sel_0,
  output logic              sel_1,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
  output logic              wb_valid,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [CNT_W-1:0]  retired,
  output logic              sel_err
);
  import mips_pkg::*;
  localparam logic [REG_AW-1:0] RA_ADDR = REG_AW'(RA_REG);
  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic [1:0]        sel_q, sel_d;
  logic [REG_AW-1:0] rd_q, rd_d, rd_n;
  logic              we_q, we_d, valid_q, valid_d, err_q, err_d;
  logic              ld, ill;
  always_comb begin
    ld      = !flush && !stall;
    ill     = wb_sel == WB_ILL;
    rd_n    = !in_valid ? '0 : wb_sel == WB_PC4 ? RA_ADDR : rd;
    a_d     = ld ? alu_result : a_q;
    b_d     = ld ? mem_rdata : b_q;
    pc_d    = ld ? pc_plus4 : pc_q;
    valid_d = flush ? 1'b0 : ld ? in_valid : valid_q;
    sel_d   = flush ? WB_ALU : ld ? ((in_valid && !ill) ? wb_sel : WB_ALU) : sel_q;
    rd_d    = flush ? '0 : ld ? rd_n : rd_q;
    we_d    = flush ? 1'b0 : ld ? (in_valid && reg_write && !ill && rd_n != ZERO_ADDR) : we_q;
    err_d   = err_q || (ld && in_valid && ill);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  retire_counter #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ld && in_valid),
    .count_o(retired)
  );
  assign wb_a        = a_q;
  assign wb_b        = b_q;
  assign wb_pc_plus4 = pc_q;
  assign sel_0       = sel_q[0];
  assign sel_1       = sel_q[1];
  assign wb_rd       = rd_q;
  assign wb_we       = we_q;
  assign wb_valid    = valid_q;
  assign sel_err     = err_q;
  assign fwd_en      = we_q;
  assign fwd_rd      = rd_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table, random traffic against a reference model, and counter wrap
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, stall, flush, reg_write;
  logic [31:0] alu_result, mem_rdata, pc_plus4;
  logic [4:0]  rd;
  logic [1:0]  wb_sel;
  logic [31:0] wb_a, wb_b, wb_pc_plus4, retired;
  logic        sel_0, sel_1, wb_we, wb_valid, fwd_en, sel_err;
  logic [4:0]  wb_rd, fwd_rd;
  always #5 clk = ~clk;
  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .rd(rd),
    .reg_write(reg_write), .wb_sel(wb_sel), .wb_a(wb_a), .wb_b(wb_b),
    .wb_pc_plus4(wb_pc_plus4), .sel_0(sel_0), .sel_1(sel_1), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_valid(wb_valid), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
    .retired(retired), .sel_err(sel_err)
  );
  int n_checks = 0, n_pass = 0;
  logic [31:0] m_a, m_b, m_pc, m_ret;
  logic [1:0]  m_sel;
  logic [4:0]  m_rd;
  logic        m_we, m_valid, m_err;
  typedef struct {
    logic rst_n, stall, flush, iv, rw;
    logic [1:0] sel;
    logic [4:0] rd;
    logic [31:0] alu, mem, pc;
    logic [1:0] e_sel;
    logic [4:0] e_rd;
    logic e_we, e_v;
    logic [31:0] e_ret;
    logic e_err;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic r, logic s, logic f, logic iv, logic rw, logic [1:0] sel,
                              logic [4:0] d, logic [31:0] a, logic [31:0] m, logic [31:0] p,
                              logic [1:0] es, logic [4:0] ed, logic ew, logic ev,
                              logic [31:0] er, logic ee);
    vec_t v;
    v.rst_n = r; v.stall = s; v.flush = f; v.iv = iv; v.rw = rw; v.sel = sel; v.rd = d;
    v.alu = a; v.mem = m; v.pc = p; v.e_sel = es; v.e_rd = ed; v.e_we = ew; v.e_v = ev;
    v.e_ret = er; v.e_err = ee;
    return v;
  endfunction
  task automatic model_edge();
    logic legal;
    if (!rst_n) begin
      {m_a, m_b, m_pc, m_ret, m_sel, m_rd, m_we, m_valid, m_err} = '0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_sel = 0; m_rd = 0;
    end else if (!stall) begin
      legal   = wb_sel != 2'b11;
      m_a     = alu_result; m_b = mem_rdata; m_pc = pc_plus4;
      m_valid = in_valid;
      m_sel   = (in_valid && legal) ? wb_sel : 2'b00;
      m_rd    = !in_valid ? 5'd0 : (wb_sel == 2'b10 ? 5'd31 : rd);
      m_we    = in_valid && reg_write && legal && m_rd != 0;
      if (in_valid) begin
        m_ret = m_ret + 1;
        if (!legal) m_err = 1;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic check(string name, logic [143:0] act, logic [143:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic check_model(string name);
    check(name,
      {wb_a, wb_b, wb_pc_plus4, sel_1, sel_0, wb_rd, wb_we, wb_valid, fwd_en, fwd_rd, retired, sel_err},
      {m_a, m_b, m_pc, m_sel, m_rd, m_we, m_valid, m_we, m_rd, m_ret, m_err});
  endtask
  task automatic drive(logic r, logic s, logic f, logic iv, logic rw, logic [1:0] sel,
                       logic [4:0] d, logic [31:0] a, logic [31:0] m, logic [31:0] p);
    rst_n = r; stall = s; flush = f; in_valid = iv; reg_write = rw; wb_sel = sel; rd = d;
    alu_result = a; mem_rdata = m; pc_plus4 = p;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tick(); tick();
    check_model("reset");
    tbl.push_back(mk(1,0,0,1,1,2'b01, 8,32'h11,32'h22,32'h33, 2'b01, 8,1,1,1,0));
    tbl.push_back(mk(0,1,0,1,1,2'b01, 8,32'h44,32'h55,32'h66, 2'b00, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,1,2'b00, 5,32'h10,32'h0,32'h100, 2'b00, 5,1,1,1,0));
    tbl.push_back(mk(1,0,0,1,1,2'b01, 6,32'h7,32'hDEADBEEF,32'h104, 2'b01, 6,1,1,2,0));
    tbl.push_back(mk(1,0,0,1,1,2'b10, 3,32'h8,32'h9,32'h404, 2'b10,31,1,1,3,0));
    tbl.push_back(mk(1,0,0,1,1,2'b00, 0,32'hA,32'hB,32'hC, 2'b00, 0,0,1,4,0));
    tbl.push_back(mk(1,0,0,1,1,2'b11, 9,32'hD,32'hE,32'hF, 2'b00, 9,0,1,5,1));
    tbl.push_back(mk(1,0,0,1,1,2'b00, 7,32'h70,32'h71,32'h72, 2'b00, 7,1,1,6,1));
    tbl.push_back(mk(1,1,0,1,1,2'b10,12,32'h80,32'h81,32'h82, 2'b00, 7,1,1,6,1));
    tbl.push_back(mk(1,1,0,1,0,2'b01,13,32'h90,32'h91,32'h92, 2'b00, 7,1,1,6,1));
    tbl.push_back(mk(1,1,0,0,1,2'b11,14,32'hA0,32'hA1,32'hA2, 2'b00, 7,1,1,6,1));
    tbl.push_back(mk(1,1,1,1,1,2'b01,15,32'hB0,32'hB1,32'hB2, 2'b00, 0,0,0,6,1));
    tbl.push_back(mk(1,0,0,0,1,2'b10, 4,32'hC0,32'hC1,32'hC2, 2'b00, 0,0,0,6,1));
    tbl.push_back(mk(1,0,0,1,0,2'b01, 4,32'hD0,32'hD1,32'hD2, 2'b01, 4,0,1,7,1));
    tbl.push_back(mk(0,0,0,1,1,2'b01, 4,32'hE0,32'hE1,32'hE2, 2'b00, 0,0,0,0,0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].iv, tbl[i].rw, tbl[i].sel,
            tbl[i].rd, tbl[i].alu, tbl[i].mem, tbl[i].pc);
      tick();
      check($sformatf("row%0d_ctrl", i),
            144'({sel_1, sel_0, wb_rd, wb_we, wb_valid, retired, sel_err}),
            144'({tbl[i].e_sel, tbl[i].e_rd, tbl[i].e_we, tbl[i].e_v, tbl[i].e_ret, tbl[i].e_err}));
      check_model($sformatf("row%0d_model", i));
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom, $urandom);
      tick();
      check_model($sformatf("rand%0d", i));
    end
    drive(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    tick();
    force dut.u_cnt.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.u_cnt.cnt_q;
    m_ret = 32'hFFFFFFFF;
    #1;
    check_model("wrap_preload");
    drive(1, 0, 0, 1, 1, 2'b00, 2, 32'h5, 32'h6, 32'h7);
    tick();
    check_model("wrap_to_zero");
    check("wrap_zero_abs", 144'(retired), 144'(0));
    drive(1, 0, 0, 0, 1, 2'b00, 2, 32'h5, 32'h6, 32'h7);
    tick();
    check_model("wrap_invalid_hold");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
